// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one 16x16 iterative multiplier between two requesters.
// Optional signed-operand support is compiled in with `define MUL_SIGNED_EN.
module mul_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][15:0] req_a,
    input  logic [1:0][15:0] req_b,
    input  logic [1:0]       req_signed,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_product,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    output logic             mul_start,
    input  logic             mul_done,
    input  logic [31:0]      mul_product
);

    localparam int unsigned  CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_prio;
    logic             r_owner;
    logic             r_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [31:0]      r_product;

    logic             w_grant;
    logic             w_accept;
    logic             w_done;
    logic             w_expire;
    logic [15:0]      w_a;
    logic [15:0]      w_b;
    logic [31:0]      w_product;

    // Tie goes to the priority pointer; otherwise the lone valid requester wins.
    assign w_grant = (req_valid == 2'b11) ? r_prio : req_valid[1];

`ifdef MUL_SIGNED_EN
    logic [15:0] w_ra;
    logic [15:0] w_rb;
    logic        w_sgn;
    logic        r_neg;

    // Operands go to the unsigned multiplier as magnitudes; sign is reapplied on capture.
    always_comb begin
        w_ra      = req_a[w_grant];
        w_rb      = req_b[w_grant];
        w_sgn     = req_signed[w_grant];
        w_a       = (w_sgn && w_ra[15]) ? (~w_ra + 16'd1) : w_ra;
        w_b       = (w_sgn && w_rb[15]) ? (~w_rb + 16'd1) : w_rb;
        w_product = r_neg ? (~mul_product + 32'd1) : mul_product;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_sgn & (w_ra[15] ^ w_rb[15]);
        end
    end
`else
    logic w_unused;

    assign w_unused  = ^req_signed;
    assign w_a       = req_a[w_grant];
    assign w_b       = req_b[w_grant];
    assign w_product = mul_product;
`endif

    // Next-state and handshake strobes.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 2'b00;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_next_state       = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    w_done       = 1'b1;
                    w_next_state = S_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_expire     = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[r_owner]) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a     <= w_a;
                r_b     <= w_b;
                r_owner <= w_grant;
                r_prio  <= ~w_grant;
                r_cnt   <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_product <= w_product;
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_product <= '0;
                r_timeout <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign mul_start   = (r_state == S_BUSY);
    assign mul_a       = r_a;
    assign mul_b       = r_b;
    assign rsp_valid   = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_product = r_product;
    assign rsp_timeout = r_timeout;

endmodule
